// File: rtl/slc3_sequencer.sv
// LC-3 control sequencer: Moore FSM that walks fetch/decode/execute and drives
// datapath gates, loads, mux selects and active-low memory strobes.
module slc3_sequencer #(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       MIO_EN,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic       DRMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT - 1);

    typedef enum logic [4:0] {
        S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKE, S_JMP,
        S_JSR1, S_JSR2, S_LDR1, S_LDR2, S_LDR3,
        S_STR1, S_STR2, S_STR3, S_PAUSE1, S_PAUSE2
    } state_t;

    typedef struct packed {
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       mio_en;
        logic       sr1mux;
        logic       addr1mux;
        logic       drmux;
        logic [1:0] addr2mux;
        logic [1:0] pcmux;
        logic [1:0] aluk;
        logic       mem_oe_n;
        logic       mem_we_n;
    } ctrl_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    ctrl_t           ctrl_q;
    logic            alu2_q;
    logic            jsr2_q;
    logic            wait_done;

    // Control word for a state; IR_5/IR_11 dependent bits are merged at the ports.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c          = '0;
        c.mem_oe_n = 1'b1;
        c.mem_we_n = 1'b1;
        case (s)
            S_FETCH1: begin
                c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; c.pcmux = 2'b00;
            end
            S_FETCH2, S_LDR2: begin
                c.mio_en = 1'b1; c.ld_mdr = 1'b1; c.mem_oe_n = 1'b0;
            end
            S_FETCH3: begin
                c.gate_mdr = 1'b1; c.ld_ir = 1'b1;
            end
            S_DECODE: c.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                c.sr1mux   = 1'b1;
                c.gate_alu = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
                c.aluk     = (s == S_ADD) ? 2'b00 : (s == S_AND) ? 2'b01 : 2'b10;
            end
            S_BR_TAKE: begin
                c.addr1mux = 1'b0; c.addr2mux = 2'b10; c.pcmux = 2'b01; c.ld_pc = 1'b1;
            end
            S_JMP: begin
                c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b00;
                c.pcmux  = 2'b01; c.ld_pc = 1'b1;
            end
            S_JSR1: begin
                c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1;
            end
            S_JSR2: begin
                c.pcmux = 2'b01; c.ld_pc = 1'b1;
            end
            S_LDR1, S_STR1: begin
                c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b01;
                c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
            end
            S_LDR3: begin
                c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
            end
            S_STR2: begin
                c.sr1mux = 1'b0; c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1;
            end
            S_STR3: c.mem_we_n = 1'b0;
            S_PAUSE1, S_PAUSE2: c.ld_led = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    assign wait_done = (cnt_q == WAIT_LAST);

    // Wait counter idles at zero everywhere else, so every memory state starts from 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_HALTED: if (Run) state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: if (wait_done) state_d = S_FETCH3; else cnt_d = cnt_q + CW'(1);
            S_FETCH3: state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    4'b0001: state_d = S_ADD;
                    4'b0101: state_d = S_AND;
                    4'b1001: state_d = S_NOT;
                    4'b0000: state_d = S_BR;
                    4'b1100: state_d = S_JMP;
                    4'b0100: state_d = S_JSR1;
                    4'b0110: state_d = S_LDR1;
                    4'b0111: state_d = S_STR1;
                    4'b1101: state_d = S_PAUSE1;
                    default: state_d = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT, S_BR_TAKE, S_JMP, S_JSR2, S_LDR3:
                state_d = S_FETCH1;
            S_BR:     state_d = BEN ? S_BR_TAKE : S_FETCH1;
            S_JSR1:   state_d = S_JSR2;
            S_LDR1:   state_d = S_LDR2;
            S_LDR2:   if (wait_done) state_d = S_LDR3; else cnt_d = cnt_q + CW'(1);
            S_STR1:   state_d = S_STR2;
            S_STR2:   state_d = S_STR3;
            S_STR3:   if (wait_done) state_d = S_FETCH1; else cnt_d = cnt_q + CW'(1);
            S_PAUSE1: if (Continue) state_d = S_PAUSE2;
            S_PAUSE2: if (!Continue) state_d = S_FETCH1;
            default:  state_d = S_HALTED;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_HALTED;
            cnt_q   <= '0;
            ctrl_q  <= ctrl_of(S_HALTED);
            alu2_q  <= 1'b0;
            jsr2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_of(state_d);
            alu2_q  <= (state_d == S_ADD) || (state_d == S_AND);
            jsr2_q  <= (state_d == S_JSR2);
        end
    end

    assign GatePC     = ctrl_q.gate_pc;
    assign GateMDR    = ctrl_q.gate_mdr;
    assign GateALU    = ctrl_q.gate_alu;
    assign GateMARMUX = ctrl_q.gate_marmux;
    assign LD_MAR     = ctrl_q.ld_mar;
    assign LD_MDR     = ctrl_q.ld_mdr;
    assign LD_IR      = ctrl_q.ld_ir;
    assign LD_BEN     = ctrl_q.ld_ben;
    assign LD_CC      = ctrl_q.ld_cc;
    assign LD_REG     = ctrl_q.ld_reg;
    assign LD_PC      = ctrl_q.ld_pc;
    assign LD_LED     = ctrl_q.ld_led;
    assign MIO_EN     = ctrl_q.mio_en;
    assign DRMUX      = ctrl_q.drmux;
    assign PCMUX      = ctrl_q.pcmux;
    assign ALUK       = ctrl_q.aluk;
    assign Mem_OE     = ctrl_q.mem_oe_n;
    assign Mem_WE     = ctrl_q.mem_we_n;

    // JSR2 picks PC+off11 (IR_11=1) or the base register (IR_11=0) live from IR.
    assign SR2MUX     = alu2_q & IR_5;
    assign SR1MUX     = ctrl_q.sr1mux   | (jsr2_q & ~IR_11);
    assign ADDR1MUX   = ctrl_q.addr1mux | (jsr2_q & ~IR_11);
    assign ADDR2MUX   = ctrl_q.addr2mux | {2{jsr2_q & IR_11}};

endmodule

// File: tb/tb_slc3_sequencer.sv
// Bench for slc3_sequencer: expected per-cycle control words are expanded from
// each instruction's phase list and compared against the DUT outputs.
module tb_slc3_sequencer;

    localparam int W = 3;

    logic       Clk, Reset, Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       MIO_EN, SR1MUX, SR2MUX, ADDR1MUX, DRMUX;
    logic [1:0] ADDR2MUX, PCMUX, ALUK;
    logic       Mem_OE, Mem_WE;

    slc3_sequencer #(.MEM_WAIT(W)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .MIO_EN(MIO_EN), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
        .DRMUX(DRMUX), .ADDR2MUX(ADDR2MUX), .PCMUX(PCMUX), .ALUK(ALUK),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    typedef struct packed {
        logic gpc, gmdr, galu, gmar;
        logic lmar, lmdr, lir, lben, lcc, lreg, lpc, lled;
        logic mio, sr1, sr2, a1, dr;
        logic [1:0] a2, pc, alu;
        logic oe, we;
    } obs_t;

    typedef enum int {
        P_HALT, P_F1, P_F2, P_F3, P_DEC, P_ADD, P_AND, P_NOT, P_BR, P_BRT, P_JMP,
        P_JSR1, P_JSR2, P_LDR1, P_LDR2, P_LDR3, P_STR1, P_STR2, P_STR3, P_P1, P_P2
    } ph_e;

    typedef struct {
        ph_e ph;
        bit  pz;
        bit  cont;
    } step_t;

    string PN [21] = '{"HALT", "F1", "F2", "F3", "DEC", "ADD", "AND", "NOT", "BR", "BRT",
                       "JMP", "JSR1", "JSR2", "LDR1", "LDR2", "LDR3", "STR1", "STR2",
                       "STR3", "P1", "P2"};

    obs_t obs;
    int   total = 0;
    int   bad   = 0;

    assign obs = '{gpc:GatePC, gmdr:GateMDR, galu:GateALU, gmar:GateMARMUX,
                   lmar:LD_MAR, lmdr:LD_MDR, lir:LD_IR, lben:LD_BEN, lcc:LD_CC,
                   lreg:LD_REG, lpc:LD_PC, lled:LD_LED, mio:MIO_EN, sr1:SR1MUX,
                   sr2:SR2MUX, a1:ADDR1MUX, dr:DRMUX, a2:ADDR2MUX, pc:PCMUX,
                   alu:ALUK, oe:Mem_OE, we:Mem_WE};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Control word each phase must present, straight from the state table.
    function automatic obs_t exp_of(input ph_e ph, input bit i5, input bit i11);
        obs_t e;
        e = '0; e.oe = 1'b1; e.we = 1'b1;
        case (ph)
            P_F1:   begin e.gpc = 1; e.lmar = 1; e.lpc = 1; e.pc = 2'b00; end
            P_F2, P_LDR2: begin e.mio = 1; e.lmdr = 1; e.oe = 0; end
            P_F3:   begin e.gmdr = 1; e.lir = 1; end
            P_DEC:  e.lben = 1;
            P_ADD:  begin e.sr1 = 1; e.sr2 = i5; e.alu = 2'b00; e.galu = 1; e.lreg = 1; e.lcc = 1; end
            P_AND:  begin e.sr1 = 1; e.sr2 = i5; e.alu = 2'b01; e.galu = 1; e.lreg = 1; e.lcc = 1; end
            P_NOT:  begin e.sr1 = 1; e.alu = 2'b10; e.galu = 1; e.lreg = 1; e.lcc = 1; end
            P_BRT:  begin e.a2 = 2'b10; e.pc = 2'b01; e.lpc = 1; end
            P_JMP:  begin e.sr1 = 1; e.a1 = 1; e.pc = 2'b01; e.lpc = 1; end
            P_JSR1: begin e.gpc = 1; e.dr = 1; e.lreg = 1; end
            P_JSR2: begin
                e.pc = 2'b01; e.lpc = 1;
                if (i11) e.a2 = 2'b11;
                else begin e.sr1 = 1; e.a1 = 1; end
            end
            P_LDR1, P_STR1: begin e.sr1 = 1; e.a1 = 1; e.a2 = 2'b01; e.gmar = 1; e.lmar = 1; end
            P_LDR3: begin e.gmdr = 1; e.lreg = 1; e.lcc = 1; end
            P_STR2: begin e.alu = 2'b11; e.galu = 1; e.lmdr = 1; end
            P_STR3: e.we = 0;
            P_P1, P_P2: e.lled = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input obs_t got, input obs_t exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Structural invariants every cycle: one bus driver at most, never OE and WE together.
    always @(negedge Clk) begin
        if (!Reset) begin
            total++;
            assert (($countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1) && (Mem_OE || Mem_WE))
            else begin
                bad++;
                $error("FAIL invariant observed=%h expected=onehot0_gates_and_no_oe_we", obs);
            end
        end
    end

    task automatic push(inout step_t q[$], input ph_e ph, input int n);
        step_t s;
        for (int k = 0; k < n; k++) begin
            s.ph = ph; s.pz = 1'b0; s.cont = 1'b0;
            q.push_back(s);
        end
    endtask

    task automatic push_pause(inout step_t q[$], input ph_e ph, input int n, input bit hold, input bit last);
        step_t s;
        for (int k = 0; k < n; k++) begin
            s.ph = ph; s.pz = 1'b1; s.cont = (k == n - 1) ? last : hold;
            q.push_back(s);
        end
    endtask

    // Expands one instruction (from FETCH1 up to the cycle before the next FETCH1) and checks it.
    task automatic run_instr(input logic [3:0] op, input bit i5, input bit i11, input bit ben,
                             input int n1, input int n2, input bit abort);
        step_t q[$];
        push(q, P_F1, 1); push(q, P_F2, W); push(q, P_F3, 1); push(q, P_DEC, 1);
        case (op)
            4'b0001: push(q, P_ADD, 1);
            4'b0101: push(q, P_AND, 1);
            4'b1001: push(q, P_NOT, 1);
            4'b0000: begin push(q, P_BR, 1); if (ben) push(q, P_BRT, 1); end
            4'b1100: push(q, P_JMP, 1);
            4'b0100: begin push(q, P_JSR1, 1); push(q, P_JSR2, 1); end
            4'b0110: begin push(q, P_LDR1, 1); push(q, P_LDR2, W); push(q, P_LDR3, 1); end
            4'b0111: begin push(q, P_STR1, 1); push(q, P_STR2, 1); push(q, P_STR3, W); end
            4'b1101: begin push_pause(q, P_P1, n1, 1'b0, 1'b1); push_pause(q, P_P2, n2, 1'b1, 1'b0); end
            default: ;
        endcase
        for (int i = 0; i < q.size(); i++) begin
            @(negedge Clk);
            chk($sformatf("%s_op%h_i%0d", PN[q[i].ph], op, i), obs, exp_of(q[i].ph, i5, i11));
            if (abort && q[i].ph == P_LDR2) begin
                #2 Reset = 1'b1;
                #1 chk("reset_mid_ldr2", obs, exp_of(P_HALT, 1'b0, 1'b0));
                Run = 1'b0;
                return;
            end
            if (i == 0) begin
                Opcode = op; IR_5 = i5; IR_11 = i11; BEN = ben;
            end
            Run      = 1'($urandom);
            Continue = q[i].pz ? q[i].cont : 1'($urandom);
        end
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
        Opcode = 4'h0; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
        #1 chk("reset_defaults", obs, exp_of(P_HALT, 1'b0, 1'b0));
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            Continue = 1'($urandom);
            @(negedge Clk);
            chk("halted_wait_run", obs, exp_of(P_HALT, 1'b0, 1'b0));
        end
        Run = 1'b1;

        run_instr(4'b0001, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0);
        run_instr(4'b0000, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
        run_instr(4'b0000, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0);
        run_instr(4'b0111, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
        run_instr(4'b1101, 1'b0, 1'b0, 1'b0, 10, 3, 1'b0);
        run_instr(4'b0100, 1'b0, 1'b1, 1'b0, 1, 1, 1'b0);
        run_instr(4'b0100, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
        run_instr(4'b0101, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
        run_instr(4'b1001, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0);
        run_instr(4'b1100, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
        run_instr(4'b0110, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
        run_instr(4'b1111, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);

        for (int n = 0; n < 150; n++)
            run_instr(4'($urandom_range(15)), 1'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 1'b0);

        run_instr(4'b0110, 1'b0, 1'b0, 1'b0, 1, 1, 1'b1);
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("halted_after_reset", obs, exp_of(P_HALT, 1'b0, 1'b0));
        end
        Run = 1'b1;
        run_instr(4'b0001, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
        @(negedge Clk);
        chk("fetch1_after_restart", obs, exp_of(P_F1, 1'b0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
